mm_mem_responder: RTL
=====================

# mm_mem_responder

Memory-side responder for the matrix-multiply engine's `i`/`j`/`index`/`read`/`write` port. It stores the dimension header and matrices A and B, serves engine reads combinationally, and captures C writes. A host loads data through a valid/ready port, releases the engine with `start`, and reads C back after the engine raises `finish`. The block sits between the host/testbench and the engine, and also drives the engine's reset.

## Interface
- `MAX_DIM`, 4: maximum rows/cols of any matrix; storage is `MAX_DIM*MAX_DIM` per matrix.
- `DATA_W`, 20: width of A/B elements, header words, and indices.
- `ACC_W`, 40: width of C elements.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `load_valid` in 1: host load strobe.
- `load_ready` out 1: high only in IDLE.
- `load_sel` in 2: 0 header, 1 A, 2 B, 3 ignored.
- `load_row`, `load_col` in DATA_W: element row/col. For header loads, `load_col` selects the word (0 rows(A), 1 cols(A), 2 cols(B)).
- `load_data` in DATA_W: value to store.
- `start` in 1: pulse; IDLE→RUN.
- `clear` in 1: pulse; DONE→IDLE.
- `mm_rst` out 1: engine reset; low only in RUN.
- `mm_i`, `mm_j` in DATA_W: engine row/col address.
- `mm_index` in 1: 0 selects A/header, 1 selects B.
- `mm_read`, `mm_write` in 1: engine strobes.
- `mm_write_data` in ACC_W: C element from engine.
- `mm_finish` in 1: engine completion.
- `mm_read_data` out DATA_W: combinational read result.
- `rd_row`, `rd_col` in DATA_W: C readback address.
- `rd_data` out ACC_W: combinational C readback.
- `done` out 1: high in DONE.
- `wr_count` out DATA_W: number of C writes accepted this run.
- `err` out 1: sticky error flag (see Configuration).

## Operation
- States:
  - **IDLE**: loads accepted, `mm_rst=1`.
  - **RUN**: engine served, `mm_rst=0`.
  - **DONE**: `mm_rst=1`, `done=1`.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE on `mm_finish`.
  - DONE→IDLE on `clear`.
  - `start` outside IDLE and `clear` outside DONE are ignored.
- **Load:** when `load_valid && load_ready`, the addressed word is written at posedge.
  - Element address = `row*MAX_DIM + col`.
  - An out-of-range row/col (≥ `MAX_DIM`, or header col > 2) is dropped.
- **Engine decode** (combinational, any state):
  - `read&&write&&!index`: returns header word `mm_i` (0..2), else 0.
  - `read&&!write&&!index`: returns `A[mm_i][mm_j]`.
  - `read&&!write&&index`: returns `B[mm_i][mm_j]`.
  - Out-of-range address or no read: returns 0.
- **C write:** `write&&!read` in RUN with an in-range address stores `mm_write_data` into `C[mm_i][mm_j]` and increments `wr_count` (saturating at all-ones). Engine writes outside RUN are ignored.
- **Entering RUN:** on the IDLE→RUN edge, all C entries and `wr_count` are cleared to 0. A and B are never cleared by the block.
- **Readback:** `rd_data = C[rd_row][rd_col]`, or 0 if out of range. Valid in every state; the host uses it in DONE.
- Arithmetic is none beyond address formation; the index product uses `clog2(MAX_DIM*MAX_DIM)` bits after the range check.

## Timing
- **Reset values:**
  - state IDLE, `mm_rst=1`, `load_ready=1`, `done=0`, `wr_count=0`, `err=0`.
  - header words 0, C all 0.
  - `mm_read_data` and `rd_data` follow their combinational rules.
- `mm_read_data` has zero latency: valid in the same cycle as the address and strobes, because the engine samples it at the next posedge.
- Loads and C writes are committed at posedge.
- `start` sampled at posedge t: `mm_rst` goes low at t (registered), so the engine's first active cycle is t+1.
- `mm_finish` sampled at posedge t: `done=1` and `mm_rst=1` from t. A C write presented in the same cycle as `mm_finish` is still committed.
- `load_valid` and `start` in the same IDLE cycle: the load commits and the state moves to RUN. Any C clear does not affect A/B.
- `reset` mid-RUN: immediately returns to IDLE and asserts `mm_rst`. A/B contents are undefined-but-unchanged; the header is cleared.

## Configuration
- **`MM_RESP_ERR_EN` defined:** `err` sets and holds until `reset` or the next `start` on any of:
  - an out-of-range load;
  - an out-of-range engine read or write in RUN;
  - `mm_read&&mm_write&&mm_index`;
  - a C write to an already-written element in the same run. This requires a `MAX_DIM²`-bit written mask.
- **Undefined:** `err` is tied 0, and no mask or compare logic is present.

## Structure
- Shared package `mm_pkg`:
  - `DATA_W`/`ACC_W` defaults;
  - state enum (IDLE, RUN, DONE);
  - `load_sel` codes (LD_HDR, LD_A, LD_B);
  - header word indices.
- One sub-module, `mm_resp_store`: a parameterised 2-D array with one synchronous write port, two combinational read ports, a range check, and a synchronous clear. It is instantiated three times (A, B, C with width `ACC_W`).
- The FSM, decode, `wr_count` and `err` live in the top.

## Test plan
- **Header read.** Load header {2,3,2}; `start`; drive `read=write=1`, `index=0`, `mm_i=0,1,2`. Required: `mm_read_data` = 2, 3, 2 in the same cycles; `mm_i=3` returns 0.
- **A/B read.** Load A[1][2]=−5 (`0xFFFFB`) and B[2][0]=7. Required: A read at (1,2) returns `0xFFFFB`; B read (`index=1`) at (2,0) returns 7.
- **Full 2×2 run** with the engine, A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Required: after `done`, C readback = 19, 22, 43, 50; `wr_count=4`; `mm_rst` high.
- **Gating.** A C write while in IDLE; `start` while in DONE. Required: both ignored, C unchanged, state stays put. `clear`, then `start` again: C all 0 and `wr_count=0` on entry to RUN.
- **Reset mid-run.** `reset` pulse mid-RUN. Required: IDLE, `mm_rst=1`, `done=0`, and header reads return 0 on the next cycle.
- **Error flag.** With `MM_RESP_ERR_EN`: a write to C[4][0] when `MAX_DIM=4` sets `err=1` sticky until the next `start`. Without the macro, `err` stays 0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply memory responder.
package mm_pkg;

   localparam int unsigned DEF_MAX_DIM = 4;
   localparam int unsigned DEF_DATA_W  = 20;
   localparam int unsigned DEF_ACC_W   = 40;

   // Responder control states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // load_sel codes; code 3 is ignored
   localparam logic [1:0] LD_HDR = 2'd0;
   localparam logic [1:0] LD_A   = 2'd1;
   localparam logic [1:0] LD_B   = 2'd2;

   // Header word indices
   localparam int unsigned HDR_ROWS_A = 0;
   localparam int unsigned HDR_COLS_A = 1;
   localparam int unsigned HDR_COLS_B = 2;
   localparam int unsigned HDR_WORDS  = 3;
   localparam int unsigned HDR_IDX_W  = 2;

endpackage

// File: rtl/mm_resp_store.sv
// 2-D element store: one synchronous write port, two combinational read ports,
// row/col range checks and a synchronous clear. With ResetClear set the array is
// also cleared by the asynchronous reset; otherwise contents survive reset.
module mm_resp_store #(
   parameter int unsigned MaxDim     = 4,
   parameter int unsigned Width      = 20,
   parameter int unsigned AddrW      = 20,
   parameter bit          ResetClear = 1'b0,
   localparam int unsigned Depth     = MaxDim * MaxDim,
   localparam int unsigned IdxW      = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             we,
   input  logic [AddrW-1:0] wr_row,
   input  logic [AddrW-1:0] wr_col,
   input  logic [Width-1:0] wr_data,
   output logic             wr_ok,
   output logic [IdxW-1:0]  wr_idx,
   input  logic [AddrW-1:0] rd0_row,
   input  logic [AddrW-1:0] rd0_col,
   output logic [Width-1:0] rd0_data,
   output logic             rd0_ok,
   input  logic [AddrW-1:0] rd1_row,
   input  logic [AddrW-1:0] rd1_col,
   output logic [Width-1:0] rd1_data,
   output logic             rd1_ok
);

   localparam logic [AddrW-1:0] DimLim = AddrW'(MaxDim);

   logic [Width-1:0] mem [Depth];
   logic [IdxW-1:0]  rd0_idx, rd1_idx;

   function automatic logic in_range(input logic [AddrW-1:0] r, input logic [AddrW-1:0] c);
      return (r < DimLim) && (c < DimLim);
   endfunction

   // Only the low bits matter once the range check has passed
   function automatic logic [IdxW-1:0] to_idx(input logic [AddrW-1:0] r,
                                              input logic [AddrW-1:0] c);
      return IdxW'(r) * IdxW'(MaxDim) + IdxW'(c);
   endfunction

   // Address decode for all ports
   always_comb begin
      wr_ok    = in_range(wr_row, wr_col);
      wr_idx   = to_idx(wr_row, wr_col);
      rd0_ok   = in_range(rd0_row, rd0_col);
      rd0_idx  = to_idx(rd0_row, rd0_col);
      rd1_ok   = in_range(rd1_row, rd1_col);
      rd1_idx  = to_idx(rd1_row, rd1_col);
      rd0_data = rd0_ok ? mem[rd0_idx] : '0;
      rd1_data = rd1_ok ? mem[rd1_idx] : '0;
   end

   if (ResetClear) begin : g_rst
      // Array update, cleared by reset
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < Depth; k++) mem[k] <= '0;
         end else if (clear) begin
            for (int k = 0; k < Depth; k++) mem[k] <= '0;
         end else if (we && wr_ok) begin
            mem[wr_idx] <= wr_data;
         end
      end
   end else begin : g_norst
      logic unused_reset;
      assign unused_reset = reset;

      // Array update, contents kept across reset
      always_ff @(posedge clk) begin
         if (clear) begin
            for (int k = 0; k < Depth; k++) mem[k] <= '0;
         end else if (we && wr_ok) begin
            mem[wr_idx] <= wr_data;
         end
      end
   end

endmodule

// File: rtl/mm_mem_responder.sv
// Memory-side responder for the matrix-multiply engine: holds the header, A and B,
// serves engine reads combinationally, captures C writes and sequences the engine
// reset. Define MM_RESP_ERR_EN to build the sticky error detector.
module mm_mem_responder
   import mm_pkg::*;
#(
   parameter int unsigned MAX_DIM = DEF_MAX_DIM,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ACC_W   = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [1:0]        load_sel,
   input  logic [DATA_W-1:0] load_row,
   input  logic [DATA_W-1:0] load_col,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic              clear,
   output logic              mm_rst,
   input  logic [DATA_W-1:0] mm_i,
   input  logic [DATA_W-1:0] mm_j,
   input  logic              mm_index,
   input  logic              mm_read,
   input  logic              mm_write,
   input  logic [ACC_W-1:0]  mm_write_data,
   input  logic              mm_finish,
   output logic [DATA_W-1:0] mm_read_data,
   input  logic [DATA_W-1:0] rd_row,
   input  logic [DATA_W-1:0] rd_col,
   output logic [ACC_W-1:0]  rd_data,
   output logic              done,
   output logic [DATA_W-1:0] wr_count,
   output logic              err
);

   localparam int unsigned Depth = MAX_DIM * MAX_DIM;
   localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [DATA_W-1:0] HdrLim = DATA_W'(HDR_WORDS);

   state_e state_q, state_d;
   logic load_fire, enter_run, in_run, c_we, c_commit, hdr_ok;
   logic [DATA_W-1:0] hdr_q [HDR_WORDS];
   logic [DATA_W-1:0] hdr_word;
   logic [DATA_W-1:0] wr_count_q;

   logic              a_wr_ok, b_wr_ok, c_wr_ok, a_rd_ok, b_rd_ok, c_rd0_ok;
   logic              a_rd1_ok, b_rd1_ok, c_rd_ok;
   logic [IdxW-1:0]   a_wr_idx, b_wr_idx, c_wr_idx;
   logic [DATA_W-1:0] a_rd_data, b_rd_data, a_rd1_data, b_rd1_data;
   logic [ACC_W-1:0]  c_rd0_data;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_d    = state_q;
      load_ready = 1'b0;
      mm_rst     = 1'b1;
      done       = 1'b0;
      case (state_q)
         StIdle: begin
            load_ready = 1'b1;
            if (start) state_d = StRun;
         end
         StRun: begin
            mm_rst = 1'b0;
            if (mm_finish) state_d = StDone;
         end
         StDone: begin
            done = 1'b1;
            if (clear) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign load_fire = load_valid && load_ready;
   assign enter_run = (state_q == StIdle) && start;
   assign in_run    = (state_q == StRun);
   assign c_we      = in_run && mm_write && !mm_read;
   assign c_commit  = c_we && c_wr_ok;
   assign hdr_ok    = mm_i < HdrLim;
   assign hdr_word  = hdr_ok ? hdr_q[mm_i[HDR_IDX_W-1:0]] : '0;
   assign wr_count  = wr_count_q;

   // Header words; row is not part of a header address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < HDR_WORDS; k++) hdr_q[k] <= '0;
      end else if (load_fire && (load_sel == LD_HDR) && (load_col < HdrLim)) begin
         hdr_q[load_col[HDR_IDX_W-1:0]] <= load_data;
      end
   end

   // Engine read decode; header access is signalled by read and write together
   always_comb begin
      mm_read_data = '0;
      if (mm_read && mm_write && !mm_index) mm_read_data = hdr_word;
      else if (mm_read && !mm_write)        mm_read_data = mm_index ? b_rd_data : a_rd_data;
   end

   // Accepted C write counter, saturating
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 wr_count_q <= '0;
      else if (enter_run)                        wr_count_q <= '0;
      else if (c_commit && (wr_count_q != '1))   wr_count_q <= wr_count_q + 1'b1;
   end

   mm_resp_store #(
      .MaxDim     (MAX_DIM),
      .Width      (DATA_W),
      .AddrW      (DATA_W),
      .ResetClear (1'b0)
   ) u_store_a (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .we       (load_fire && (load_sel == LD_A)),
      .wr_row   (load_row),
      .wr_col   (load_col),
      .wr_data  (load_data),
      .wr_ok    (a_wr_ok),
      .wr_idx   (a_wr_idx),
      .rd0_row  (mm_i),
      .rd0_col  (mm_j),
      .rd0_data (a_rd_data),
      .rd0_ok   (a_rd_ok),
      .rd1_row  (rd_row),
      .rd1_col  (rd_col),
      .rd1_data (a_rd1_data),
      .rd1_ok   (a_rd1_ok)
   );

   mm_resp_store #(
      .MaxDim     (MAX_DIM),
      .Width      (DATA_W),
      .AddrW      (DATA_W),
      .ResetClear (1'b0)
   ) u_store_b (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .we       (load_fire && (load_sel == LD_B)),
      .wr_row   (load_row),
      .wr_col   (load_col),
      .wr_data  (load_data),
      .wr_ok    (b_wr_ok),
      .wr_idx   (b_wr_idx),
      .rd0_row  (mm_i),
      .rd0_col  (mm_j),
      .rd0_data (b_rd_data),
      .rd0_ok   (b_rd_ok),
      .rd1_row  (rd_row),
      .rd1_col  (rd_col),
      .rd1_data (b_rd1_data),
      .rd1_ok   (b_rd1_ok)
   );

   mm_resp_store #(
      .MaxDim     (MAX_DIM),
      .Width      (ACC_W),
      .AddrW      (DATA_W),
      .ResetClear (1'b1)
   ) u_store_c (
      .clk      (clk),
      .reset    (reset),
      .clear    (enter_run),
      .we       (c_we),
      .wr_row   (mm_i),
      .wr_col   (mm_j),
      .wr_data  (mm_write_data),
      .wr_ok    (c_wr_ok),
      .wr_idx   (c_wr_idx),
      .rd0_row  (mm_i),
      .rd0_col  (mm_j),
      .rd0_data (c_rd0_data),
      .rd0_ok   (c_rd0_ok),
      .rd1_row  (rd_row),
      .rd1_col  (rd_col),
      .rd1_data (rd_data),
      .rd1_ok   (c_rd_ok)
   );

   logic unused_ports;
   assign unused_ports = ^{a_rd1_data, a_rd1_ok, b_rd1_data, b_rd1_ok, b_rd_ok, c_rd0_data,
                           c_rd0_ok, c_rd_ok, a_wr_idx, b_wr_idx, b_wr_ok};

`ifdef MM_RESP_ERR_EN
   logic [Depth-1:0] written_q;
   logic             err_q, err_set, load_bad, eng_bad;

   assign load_bad = load_fire && (((load_sel == LD_HDR) && !(load_col < HdrLim)) ||
                                   (((load_sel == LD_A) || (load_sel == LD_B)) && !a_wr_ok));
   assign eng_bad  = in_run && ((mm_read && mm_write && mm_index) ||
                                (mm_read && mm_write && !mm_index && !hdr_ok) ||
                                (mm_read && !mm_write && !a_rd_ok) ||
                                (c_we && !c_wr_ok) ||
                                (c_commit && written_q[c_wr_idx]));
   assign err_set  = load_bad || eng_bad;
   assign err      = err_q;

   // Sticky error and per-run written mask; start clears both
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q     <= 1'b0;
         written_q <= '0;
      end else begin
         err_q <= err_set || (err_q && !enter_run);
         if (enter_run)     written_q           <= '0;
         else if (c_commit) written_q[c_wr_idx] <= 1'b1;
      end
   end
`else
   logic unused_err;
   assign unused_err = ^{c_wr_idx, a_rd_ok};
   assign err        = 1'b0;
`endif

endmodule
